// File: rtl/bsg_coatcheck_pkg.sv
// Width helpers shared by the coat-check table and its metadata store.
package bsg_coatcheck_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bsg_coatcheck_meta_mem.sv
// Per-id metadata flop array (1 sync write, 1 async read) and busy vector.
module bsg_coatcheck_meta_mem
  import bsg_coatcheck_pkg::*;
#(
  parameter  int els_p        = 4,
  parameter  int meta_width_p = 8,
  localparam int id_width_lp  = safe_clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    w_v_i,
  input  logic [id_width_lp-1:0]  w_id_i,
  input  logic [meta_width_p-1:0] w_meta_i,
  input  logic [id_width_lp-1:0]  r_id_i,
  output logic [meta_width_p-1:0] r_meta_o,
  input  logic                    clr_v_i,
  input  logic [id_width_lp-1:0]  clr_id_i,
  output logic [els_p-1:0]        busy_o
);

  logic [meta_width_p-1:0] meta_q [els_p];
  logic [meta_width_p-1:0] meta_d [els_p];
  logic [els_p-1:0]        busy_q, busy_d;

  always_comb begin
    meta_d = meta_q;
    busy_d = busy_q;
    for (int i = 0; i < els_p; i++) begin
      if (clr_v_i && clr_id_i == id_width_lp'(i)) busy_d[i] = 1'b0;
      // set after clear so a same-cycle re-issue keeps the id busy
      if (w_v_i && w_id_i == id_width_lp'(i)) begin
        busy_d[i] = 1'b1;
        meta_d[i] = w_meta_i;
      end
    end
  end

  always_comb begin
    r_meta_o = '0;
    for (int i = 0; i < els_p; i++)
      if (r_id_i == id_width_lp'(i)) r_meta_o = meta_q[i];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) busy_q <= '0;
    else            busy_q <= busy_d;
  end

  always_ff @(posedge clk_i) begin
    meta_q <= meta_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/bsg_coatcheck_table.sv
// Tags requests with pool ids, stores metadata, and pairs returning responses.
module bsg_coatcheck_table
  import bsg_coatcheck_pkg::*;
#(
  parameter  int els_p          = 4,
  parameter  int meta_width_p   = 8,
  parameter  int data_width_p   = 32,
  localparam int id_width_lp    = safe_clog2(els_p),
  localparam int count_width_lp = count_width(els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      pool_alloc_v_i,
  input  logic [id_width_lp-1:0]    pool_alloc_id_i,
  output logic                      pool_alloc_yumi_o,
  output logic                      pool_dealloc_v_o,
  output logic [id_width_lp-1:0]    pool_dealloc_id_o,
  input  logic                      req_v_i,
  input  logic [meta_width_p-1:0]   req_meta_i,
  output logic                      req_ready_o,
  output logic                      req_v_o,
  output logic [id_width_lp-1:0]    req_id_o,
  input  logic                      req_ready_i,
  input  logic                      resp_v_i,
  input  logic [id_width_lp-1:0]    resp_id_i,
  input  logic [data_width_p-1:0]   resp_data_i,
  output logic                      resp_ready_o,
  output logic                      resp_v_o,
  output logic [id_width_lp-1:0]    resp_id_o,
  output logic [meta_width_p-1:0]   resp_meta_o,
  output logic [data_width_p-1:0]   resp_data_o,
  input  logic                      resp_yumi_i,
  output logic [count_width_lp-1:0] outstanding_o,
  output logic                      empty_o
);

  logic                      fire, accept;
  logic [meta_width_p-1:0]   rd_meta;
  logic [els_p-1:0]          busy;
  logic                      resp_v_q, resp_v_d;
  logic [id_width_lp-1:0]    resp_id_q, resp_id_d;
  logic [meta_width_p-1:0]   resp_meta_q, resp_meta_d;
  logic [data_width_p-1:0]   resp_data_q, resp_data_d;
  logic [count_width_lp-1:0] cnt_q, cnt_d;

  assign req_ready_o = pool_alloc_v_i & req_ready_i;
  assign req_v_o     = req_v_i & pool_alloc_v_i;
  assign req_id_o    = pool_alloc_id_i;
  assign fire        = req_v_i & req_ready_o;

  assign pool_alloc_yumi_o = fire;

  assign resp_ready_o = ~resp_v_q | resp_yumi_i;
  assign accept       = resp_v_i & resp_ready_o;

  assign pool_dealloc_v_o  = accept;
  assign pool_dealloc_id_o = resp_id_i;

  bsg_coatcheck_meta_mem #(
    .els_p        (els_p),
    .meta_width_p (meta_width_p)
  ) u_mem (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .w_v_i     (fire),
    .w_id_i    (pool_alloc_id_i),
    .w_meta_i  (req_meta_i),
    .r_id_i    (resp_id_i),
    .r_meta_o  (rd_meta),
    .clr_v_i   (accept),
    .clr_id_i  (resp_id_i),
    .busy_o    (busy)
  );

  always_comb begin
    resp_v_d    = accept | (resp_v_q & ~resp_yumi_i);
    resp_id_d   = resp_id_q;
    resp_meta_d = resp_meta_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      resp_id_d   = resp_id_i;
      resp_meta_d = rd_meta;
      resp_data_d = resp_data_i;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      fire & ~accept: cnt_d = cnt_q + count_width_lp'(1);
      accept & ~fire: cnt_d = cnt_q - count_width_lp'(1);
      default:        cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resp_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      resp_v_q <= resp_v_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    resp_id_q   <= resp_id_d;
    resp_meta_q <= resp_meta_d;
    resp_data_q <= resp_data_d;
  end

  assign resp_v_o      = resp_v_q;
  assign resp_id_o     = resp_id_q;
  assign resp_meta_o   = resp_meta_q;
  assign resp_data_o   = resp_data_q;
  assign outstanding_o = cnt_q;
  assign empty_o       = (cnt_q == '0);

`ifndef SYNTHESIS
  logic resp_busy;

  always_comb begin
    resp_busy = 1'b0;
    for (int i = 0; i < els_p; i++)
      if (resp_id_i == id_width_lp'(i)) resp_busy = busy[i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      if (accept)
        assert (resp_busy)
          else $error("response for idle id %0d", resp_id_i);
      if (resp_yumi_i)
        assert (resp_v_q)
          else $error("yumi without valid output");
      if (fire && !accept)
        assert (cnt_q != count_width_lp'(els_p))
          else $error("request fired with all ids outstanding");
    end
  end
`endif

endmodule
